// File: rtl/serial_pattern_capture_if.sv
// Bus bundle for serial_pattern_capture: capture controls in, frame and status out.
interface serial_pattern_capture_if #(
    parameter int NBITS = 17,
    parameter int CW    = 5
);
    logic             START;
    logic             EN;
    logic             D;
    logic [NBITS-1:0] C;
    logic [CW-1:0]    CNT;
    logic             BUSY;
    logic             DONE;

    modport master (output START, EN, D, input C, CNT, BUSY, DONE);
    modport slave  (input START, EN, D, output C, CNT, BUSY, DONE);
endinterface

// File: rtl/serial_pattern_capture.sv
// Serial frame capture: collects NBITS strobed bits LSB first into a shadow
// register and publishes the whole frame on C only when it is complete.
//
// state   | meaning
// IDLE    | waiting for START; strobes ignored
// CAPTURE | collecting bits on EN strobes
module serial_pattern_capture #(
    parameter int NBITS = 17,
    parameter int CW    = 5
) (
    input  logic                    CK,
    input  logic                    RST,
    serial_pattern_capture_if.slave bus
);
    typedef enum logic {
        IDLE,
        CAPTURE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [NBITS-2:0] shadow;
    logic [NBITS-1:0] frame;
    logic             done;

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            shadow <= '0;
            frame  <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        state  <= CAPTURE;
                        cnt    <= '0;
                        shadow <= '0;
                    end
                end
                CAPTURE: begin
                    // START restarts the frame and discards any bit strobed alongside it
                    if (bus.START) begin
                        cnt    <= '0;
                        shadow <= '0;
                    end else if (bus.EN) begin
                        if (cnt == CW'(NBITS - 1)) begin
                            frame <= {bus.D, shadow};
                            done  <= 1'b1;
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            for (int i = 0; i < NBITS - 1; i++) begin
                                if (cnt == CW'(i)) shadow[i] <= bus.D;
                            end
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.C    = frame;
    assign bus.CNT  = cnt;
    assign bus.BUSY = (state == CAPTURE);
    assign bus.DONE = done;
endmodule

// File: doc/serial_pattern_capture.md
SERIAL_PATTERN_CAPTURE -- requirements
Module: serial_pattern_capture

Interface
REQ-001 SHALL have parameter NBITS, default 17, meaning frame length in bits (legal range 2..32).
REQ-002 SHALL have parameter CW, default 5, meaning index/count width; CW SHALL satisfy 2^CW > NBITS.
REQ-003 SHALL have port CK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port START  input  1  begin a new frame capture (level sampled each edge).
REQ-006 SHALL have port EN  input  1  bit strobe; D valid when EN=1.
REQ-007 SHALL have port D  input  1  serial data bit, frame bit 0 first.
REQ-008 SHALL have port C  output  NBITS  last completed frame, C[i] = i-th received bit.
REQ-009 SHALL have port CNT  output  CW  number of bits captured in the current frame.
REQ-010 SHALL have port BUSY  output  1  high while in CAPTURE.
REQ-011 SHALL have port DONE  output  1  one-cycle pulse on frame completion.

Function
REQ-012 SHALL implement FSM states IDLE and CAPTURE, with state, CNT, shadow register, C and DONE all registered.
REQ-013 IDLE: START=1 SHALL go to CAPTURE, CNT<=0, shadow<=0; EN in the same cycle SHALL be ignored.
REQ-014 IDLE with START=0: EN and D SHALL be ignored; CNT and C SHALL hold.
REQ-015 CAPTURE, EN=1, START=0, CNT<NBITS-1: shadow[CNT]<=D and CNT<=CNT+1.
REQ-016 CAPTURE, EN=1, START=0, CNT=NBITS-1: C<={D,shadow[NBITS-2:0]} with D in bit NBITS-1, DONE<=1, CNT<=0, state<=IDLE, all on the same edge.
REQ-017 DONE SHALL be high exactly one cycle, the cycle after the final strobe edge; otherwise DONE<=0 every edge.
REQ-018 CAPTURE, EN=0, START=0: SHALL hold all state; there is no timeout.
REQ-019 CAPTURE with START=1 (any EN): SHALL restart, CNT<=0, shadow<=0, remain CAPTURE, discard the EN bit, and leave C unchanged.
REQ-020 START=1 in the cycle DONE is high (state IDLE) SHALL start a new frame per REQ-013.
REQ-021 C SHALL change only on a frame completion edge (REQ-016) or reset; partial frames SHALL never appear on C.
REQ-022 BUSY SHALL equal (state==CAPTURE); CNT SHALL never exceed NBITS-1.
REQ-023 Latency: bit i SHALL be sampled on the edge where EN=1; frame visible on C one edge after the final strobe.

Reset
REQ-024 RST=1 SHALL asynchronously force state=IDLE, CNT=0, shadow=0, C=0, DONE=0, BUSY=0.
REQ-025 RST asserted mid-frame SHALL abandon the frame; after release the block SHALL require START before capturing.
REQ-026 The first edge after RST deassertion SHALL evaluate inputs normally (START on that edge is honoured).

Verification
REQ-027 Reset then START, 17 consecutive strobes D=1,0,1,0,... -> DONE pulse 1 cycle after 17th strobe, C=17'h15555, BUSY low, CNT=0.
REQ-028 START, strobes with EN gaps of 0..3 idle cycles, D=all ones -> C=17'h1FFFF only after 17th strobe; CNT steps only on EN cycles.
REQ-029 START, 9 strobes, START+EN together, then 17 strobes D=0 -> no DONE before the last strobe; C=0; earlier partial bits absent.
REQ-030 Complete frame C=17'h0AAAA, then RST pulse after 5 strobes of the next frame -> C=0, BUSY=0, later strobes without START ignored.
REQ-031 Back-to-back: START held during the DONE cycle, second frame D=1 only at bit 16 -> second DONE, C=17'h10000.
REQ-032 EN pulses with START=0 in IDLE -> CNT, C, DONE unchanged for all cycles.
